// File: rtl/lsu.sv
// Load/store unit: byte/halfword/word accesses to a word-organised RAM with
// read-modify-write for sub-word stores and sign/zero extension on loads.
module lsu #(
  parameter int WORDS = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        store,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [31:0] WORDS_W = 32'(WORDS);

  state_t      state, state_nxt;
  logic        store_q;
  logic        sext_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;
  logic        err_q;
  logic        chk_err;

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  sz,
                                               input logic [1:0]  off,
                                               input logic        sx);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   r = {{24{sx & b[7]}}, b};
      2'b01:   r = {{16{sx & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  off,
                                              input logic [31:0] wd);
    logic [31:0] r;
    r = word;
    if (sz == 2'b00) begin
      r[{off, 3'b000} +: 8] = wd[7:0];
    end else if (sz == 2'b01) begin
      if (off[1]) r[31:16] = wd[15:0];
      else        r[15:0]  = wd[15:0];
    end
    return r;
  endfunction

  // Alignment, size and range checks are made on the raw request at accept.
  always_comb begin
    chk_err = 1'b0;
    case (size)
      2'b01:   chk_err = addr[0];
      2'b10:   chk_err = (addr[1:0] != 2'b00);
      2'b11:   chk_err = 1'b1;
      default: chk_err = 1'b0;
    endcase
    if ({2'b00, addr[31:2]} >= WORDS_W) chk_err = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (chk_err)                       state_nxt = DONE;
          else if (store && size == 2'b10)   state_nxt = WRITE;
          else                               state_nxt = READ;
        end
      end
      READ:    state_nxt = store_q ? WRITE : DONE;
      WRITE:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // mem_wdata holds the raw store data until READ replaces it with the merged word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      store_q   <= 1'b0;
      sext_q    <= 1'b0;
      size_q    <= 2'b00;
      off_q     <= 2'b00;
      err_q     <= 1'b0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req) begin
            store_q <= store;
            sext_q  <= sign_ext;
            size_q  <= size;
            off_q   <= addr[1:0];
            err_q   <= chk_err;
            if (!chk_err) begin
              mem_addr  <= {2'b00, addr[31:2]};
              mem_wdata <= wdata;
            end
          end
        end
        READ: begin
          if (store_q) mem_wdata <= merge_store(mem_rdata, size_q, off_q, mem_wdata);
          else         rdata     <= load_extract(mem_rdata, size_q, off_q, sext_q);
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign done   = (state == DONE);
  assign err    = done & err_q;
  assign mem_we = (state == WRITE);

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: table of single transactions against a RAM model,
// plus hand-written sequences for continuous req and reset during RMW.
module tb_lsu;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic        store = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err, mem_we;
  logic [31:0] rdata, mem_addr, mem_rdata, mem_wdata;

  logic [31:0] mem [256];
  int          wr_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  lsu #(.WORDS(256)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .store(store), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .busy(busy), .done(done),
    .rdata(rdata), .err(err), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'h0;

  always @(posedge clk) begin
    if (mem_we) begin
      wr_cnt <= wr_cnt + 1;
      if (mem_addr < 32'd256) mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        se;
    logic [31:0] a;
    logic [31:0] wd;
    int          lat;
    logic        er;
    logic [31:0] rd;
    int          wr;
    int          idx;
    logic [31:0] mv;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    @(negedge clk);
    while (busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: got busy=1 expected busy=0");
    end
  endtask

  task automatic run_op(input logic st, input logic [1:0] sz, input logic se,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic got_err, output logic [31:0] got_rd);
    wait_idle();
    req = 1'b1; store = st; size = sz; sign_ext = se; addr = a; wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0;
    lat = -1;
    for (int n = 1; n <= 10; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      @(posedge clk);
      #1;
    end
    got_err = err;
    got_rd  = rdata;
  endtask

  initial begin
    int          lat;
    logic        e;
    logic [31:0] r;
    logic [31:0] last_rd;
    logic [31:0] exp_rd;
    int          w0;
    logic [12:0] mask;

    for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    #0;
    mem[4]   <= 32'h11223344;
    mem[5]   <= 32'h0000F080;
    mem[6]   <= 32'h12345678;
    mem[255] <= 32'hCAFEF00D;

    //          st    sz     se    addr       wdata         lat er    rd            wr idx mv
    vecs[0]  = '{1'b1, 2'b00, 1'b0, 32'h12,  32'h000000AA, 3, 1'b0, 32'h0,        1, 4,  32'h11AA3344};
    vecs[1]  = '{1'b1, 2'b01, 1'b0, 32'h1A,  32'hFFFFBEEF, 3, 1'b0, 32'h0,        1, 6,  32'hBEEF5678};
    vecs[2]  = '{1'b1, 2'b10, 1'b0, 32'h10,  32'hDEADBEEF, 2, 1'b0, 32'h0,        1, 4,  32'hDEADBEEF};
    vecs[3]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,        2, 1'b0, 32'hDEADBEEF, 0, -1, 32'h0};
    vecs[4]  = '{1'b0, 2'b00, 1'b1, 32'h14,  32'h0,        2, 1'b0, 32'hFFFFFF80, 0, -1, 32'h0};
    vecs[5]  = '{1'b0, 2'b00, 1'b0, 32'h14,  32'h0,        2, 1'b0, 32'h00000080, 0, -1, 32'h0};
    vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h14,  32'h0,        2, 1'b0, 32'hFFFFF080, 0, -1, 32'h0};
    vecs[7]  = '{1'b0, 2'b01, 1'b0, 32'h14,  32'h0,        2, 1'b0, 32'h0000F080, 0, -1, 32'h0};
    vecs[8]  = '{1'b0, 2'b00, 1'b1, 32'h15,  32'h0,        2, 1'b0, 32'hFFFFFFF0, 0, -1, 32'h0};
    vecs[9]  = '{1'b0, 2'b00, 1'b0, 32'h1B,  32'h0,        2, 1'b0, 32'h000000BE, 0, -1, 32'h0};
    vecs[10] = '{1'b0, 2'b01, 1'b1, 32'h1A,  32'h0,        2, 1'b0, 32'hFFFFBEEF, 0, -1, 32'h0};
    vecs[11] = '{1'b0, 2'b01, 1'b1, 32'h13,  32'h0,        1, 1'b1, 32'h0,        0, -1, 32'h0};
    vecs[12] = '{1'b1, 2'b10, 1'b0, 32'h400, 32'h0000DEAD, 1, 1'b1, 32'h0,        0, 4,  32'hDEADBEEF};
    vecs[13] = '{1'b0, 2'b11, 1'b0, 32'h10,  32'h0,        1, 1'b1, 32'h0,        0, -1, 32'h0};
    vecs[14] = '{1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0,        2, 1'b0, 32'hCAFEF00D, 0, -1, 32'h0};
    vecs[15] = '{1'b1, 2'b10, 1'b0, 32'h12,  32'h55555555, 1, 1'b1, 32'h0,        0, 4,  32'hDEADBEEF};
    vecs[16] = '{1'b0, 2'b00, 1'b0, 32'h400, 32'h0,        1, 1'b1, 32'h0,        0, -1, 32'h0};
    vecs[17] = '{1'b1, 2'b00, 1'b0, 32'h17,  32'h00000055, 3, 1'b0, 32'h0,        1, 5,  32'h5500F080};
    vecs[18] = '{1'b0, 2'b10, 1'b0, 32'h14,  32'h0,        2, 1'b0, 32'h5500F080, 0, -1, 32'h0};

    #1;
    check("reset_outputs", {28'h0, busy, done, err, mem_we}, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_mem_wdata", mem_wdata, 32'h0);
    #20;
    @(negedge clk);
    reset_n = 1'b1;

    last_rd = 32'h0;
    for (int i = 0; i < 19; i++) begin
      w0 = wr_cnt;
      run_op(vecs[i].st, vecs[i].sz, vecs[i].se, vecs[i].a, vecs[i].wd, lat, e, r);
      if (!vecs[i].st && !vecs[i].er) last_rd = vecs[i].rd;
      exp_rd = last_rd;
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d err", i), {31'h0, e}, {31'h0, vecs[i].er});
      check($sformatf("v%0d rdata", i), r, exp_rd);
      check($sformatf("v%0d writes", i), 32'(wr_cnt - w0), 32'(vecs[i].wr));
      if (vecs[i].idx >= 0)
        check($sformatf("v%0d mem[%0d]", i, vecs[i].idx), mem[vecs[i].idx], vecs[i].mv);
    end

    // req held high: accepts every N+1 = 3 cycles, done one cycle wide.
    wait_idle();
    req = 1'b1; store = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h10; wdata = '0;
    mask = '0;
    @(posedge clk);
    for (int n = 1; n <= 12; n++) begin
      #1;
      mask[n] = done;
      @(posedge clk);
    end
    req = 1'b0;
    check("busy_done_pattern", {19'h0, mask}, 32'h00000924);

    // Reset while a byte store sits in READ: no write may occur.
    wait_idle();
    mem[4] <= 32'h11223344;
    req = 1'b1; store = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h12; wdata = 32'hAA;
    w0 = wr_cnt;
    @(posedge clk);
    #1;
    req = 1'b0;
    check("rmw_in_read", {30'h0, busy, mem_we}, 32'h2);
    #2;
    reset_n = 1'b0;
    #1;
    check("midreset_ctrl", {28'h0, busy, done, err, mem_we}, 32'h0);
    check("midreset_rdata", rdata, 32'h0);
    check("midreset_mem_addr", mem_addr, 32'h0);
    check("midreset_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midreset_mem4", mem[4], 32'h11223344);
    check("midreset_writes", 32'(wr_cnt - w0), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    w0 = wr_cnt;
    run_op(1'b1, 2'b00, 1'b0, 32'h12, 32'hAA, lat, e, r);
    check("after_reset_latency", 32'(lat), 32'd3);
    check("after_reset_err", {31'h0, e}, 32'h0);
    check("after_reset_mem4", mem[4], 32'h11AA3344);
    check("after_reset_writes", 32'(wr_cnt - w0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
